// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_DATA_BITS      = 8;
  localparam int PS2_INHIBIT_CYCLES = 5000;    // 100us @ 50MHz
  localparam int PS2_TIMEOUT_CYCLES = 750000;  // 15ms @ 50MHz

  // Odd parity bit for one PS/2 data byte.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the asynchronous PS/2 clock/data lines into the clk domain and
// flags falling edges of the synchronised clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic data_meta;
  logic clk_prev;

  // Two-flop synchronisers plus one history flop for edge detection; idle lines read high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Falling edge of the synchronised clock line.
  always_comb begin
    clk_fall = clk_prev & ~clk_sync;
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte and checks the device ACK.
//
// state     | meaning
// IDLE      | lines released, waiting for tx_valid
// INHIBIT   | clock held low; data pulled low on the last cycle (request-to-send)
// REQ       | clock released, start bit (data low) waiting for first device fall
// DATA      | placing data bits LSB first on each device clock fall
// PARITY    | parity bit on the line, waiting for the fall that releases data
// STOP      | stop bit (released) on the line, ACK sampled on next fall
// WAIT_IDLE | ACK seen, waiting for both lines to return high
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e state_q, state_d;
  logic [PS2_DATA_BITS:0] shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]       inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   clk_low_d, data_low_d, done_d, err_d;
  logic                   clk_sync, data_sync, clk_fall;
  logic                   in_frame, timeout;

  ps2_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  // Next-state, shift/counter updates and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    clk_low_d  = ps2_clk_drive_low;
    data_low_d = ps2_data_drive_low;
    done_d     = 1'b0;
    err_d      = 1'b0;
    in_frame   = (state_q != IDLE) && (state_q != INHIBIT);
    timeout    = in_frame && (tmo_cnt_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (tx_valid && tx_ready) begin
          // Parity sits above the data byte so it shifts out right after bit7.
          shift_d    = {ps2_odd_parity(tx_data), tx_data};
          inh_cnt_d  = INH_LOAD;
          clk_low_d  = 1'b1;
          data_low_d = (INHIBIT_CYCLES == 1);
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == '0) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q - INH_W'(1);
          if (inh_cnt_q == INH_W'(1)) data_low_d = 1'b1;
        end
      end
      REQ: begin
        if (clk_fall) begin
          data_low_d = ~shift_q[0];
          shift_d    = shift_q >> 1;
          bit_cnt_d  = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (clk_fall) begin
          data_low_d = ~shift_q[0];
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (clk_fall) begin
          data_low_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          if (!data_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout overrides whatever the frame logic decided this cycle.
    if (in_frame) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      if (timeout) begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b1;
        state_d    = IDLE;
      end
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      shift_q            <= '0;
      bit_cnt_q          <= '0;
      inh_cnt_q          <= '0;
      tmo_cnt_q          <= '0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      tx_ready           <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
    end else begin
      state_q            <= state_d;
      shift_q            <= shift_d;
      bit_cnt_q          <= bit_cnt_d;
      inh_cnt_q          <= inh_cnt_d;
      tmo_cnt_q          <= tmo_cnt_d;
      ps2_clk_drive_low  <= clk_low_d;
      ps2_data_drive_low <= data_low_d;
      tx_ready           <= (state_d == IDLE);
      busy               <= (state_d != IDLE);
      done               <= done_d;
      err                <= err_d;
    end
  end

endmodule
